// File: rtl/wide_bus_assembler.sv
// Collects IN_W-bit valid/ready beats into an OUT_W-bit frame and holds it on a valid/ready output.
// Optional WIDE_ASM_OVERLAP_EN: keep filling the accumulator while the previous frame is held.
module wide_bus_assembler #(
    parameter  int IN_W  = 32,
    parameter  int OUT_W = 1024,
    parameter  int CNT_W = 16,
    localparam int BEATS = OUT_W / IN_W,
    localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic             main_clk_100mhz,
    input  logic             reset_n,
    input  logic [IN_W-1:0]  s_data,
    input  logic             s_valid,
    input  logic             s_last,
    output logic             s_ready,
    output logic [OUT_W-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [IDX_W-1:0] beat_idx,
    output logic             frame_err,
    output logic [CNT_W-1:0] frame_count
);

    typedef enum logic [0:0] {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [OUT_W-1:0]   acc;
    logic [OUT_W-1:0]   assembled;
    logic               accept;
    logic               last_slot;
    logic               completing_beat;
    logic               complete;
    logic               handshake;

    always_comb begin
        m_valid         = (state == HOLD);
        last_slot       = (beat_idx == IDX_W'(BEATS - 1));
        completing_beat = last_slot || s_last;
`ifdef WIDE_ASM_OVERLAP_EN
        // Only the beat that would overwrite a still-held frame has to wait.
        s_ready         = !(m_valid && !m_ready && completing_beat);
`else
        s_ready         = !m_valid;
`endif
        accept          = s_valid && s_ready;
        complete        = accept && completing_beat;
        handshake       = m_valid && m_ready;
        // Upper slots of acc are always zero, so short frames arrive zero-padded.
        assembled       = acc;
        assembled[int'(beat_idx) * IN_W +: IN_W] = s_data;
    end

    always_comb begin
        next_state = state;
        case (state)
            FILL:    if (complete) next_state = HOLD;
            HOLD:    if (handshake && !complete) next_state = FILL;
            default: next_state = FILL;
        endcase
    end

    always_ff @(posedge main_clk_100mhz or negedge reset_n) begin
        if (!reset_n) begin
            state <= FILL;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge main_clk_100mhz or negedge reset_n) begin
        if (!reset_n) begin
            acc         <= '0;
            m_data      <= '0;
            beat_idx    <= '0;
            frame_err   <= 1'b0;
            frame_count <= '0;
        end else begin
            if (accept) begin
                if (completing_beat) begin
                    acc      <= '0;
                    beat_idx <= '0;
                    m_data   <= assembled;
                end else begin
                    acc      <= assembled;
                    beat_idx <= beat_idx + IDX_W'(1);
                end
            end
            frame_err <= complete && !last_slot;
            if (handshake) begin
                frame_count <= frame_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_wide_bus_assembler.sv
// Directed self-checking bench for wide_bus_assembler (default geometry, narrowed frame counter).
module tb_wide_bus_assembler;

    localparam int IN_W  = 32;
    localparam int OUT_W = 1024;
    localparam int CNT_W = 8;

    logic             main_clk_100mhz = 1'b0;
    logic             reset_n = 1'b0;
    logic [IN_W-1:0]  s_data = '0;
    logic             s_valid = 1'b0;
    logic             s_last = 1'b0;
    logic             s_ready;
    logic [OUT_W-1:0] m_data;
    logic             m_valid;
    logic             m_ready = 1'b0;
    logic [4:0]       beat_idx;
    logic             frame_err;
    logic [CNT_W-1:0] frame_count;

    int checks = 0;
    int errors = 0;

    wide_bus_assembler #(.IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
        .main_clk_100mhz(main_clk_100mhz),
        .reset_n(reset_n),
        .s_data(s_data),
        .s_valid(s_valid),
        .s_last(s_last),
        .s_ready(s_ready),
        .m_data(m_data),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .beat_idx(beat_idx),
        .frame_err(frame_err),
        .frame_count(frame_count)
    );

    always #5 main_clk_100mhz = ~main_clk_100mhz;

    task automatic check(input string tag, input logic [OUT_W-1:0] obs, input logic [OUT_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge main_clk_100mhz);
        #1;
    endtask

    // Offers one beat, waits (bounded) for s_ready, returns 1 time unit after the accepting edge.
    task automatic send_beat(input logic [IN_W-1:0] d, input logic l);
        int n;
        n = 0;
        s_data  = d;
        s_last  = l;
        s_valid = 1'b1;
        while (!s_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) check("s_ready_timeout", 1'b0, 1'b1);
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    initial begin
        #12;
        check("rst_m_valid", m_valid, 1'b0);
        check("rst_m_data", m_data, '0);
        check("rst_beat_idx", beat_idx, 5'd0);
        check("rst_frame_err", frame_err, 1'b0);
        check("rst_frame_count", frame_count, 8'd0);
        @(negedge main_clk_100mhz);
        reset_n = 1'b1;
        tick();
        check("idle_s_ready", s_ready, 1'b1);

        // Full frame, consumer always ready.
        m_ready = 1'b1;
        for (int i = 0; i < 31; i++) send_beat(32'(i), 1'b0);
        check("t1_idx31", beat_idx, 5'd31);
        check("t1_no_valid_yet", m_valid, 1'b0);
        send_beat(32'd31, 1'b0);
        check("t1_m_valid", m_valid, 1'b1);
        check("t1_low_word", m_data[31:0], 32'd0);
        check("t1_high_word", m_data[1023:992], 32'd31);
        check("t1_word5", m_data[191:160], 32'd5);
        check("t1_frame_err", frame_err, 1'b0);
        check("t1_beat_idx", beat_idx, 5'd0);
        tick();
        check("t1_valid_drop", m_valid, 1'b0);
        check("t1_count", frame_count, 8'd1);

        // Held output under back-pressure.
        m_ready = 1'b0;
        for (int i = 0; i < 32; i++) send_beat(32'hA000_0000 | 32'(i), 1'b0);
        for (int c = 0; c < 10; c++) begin
            check("t2_hold_valid", m_valid, 1'b1);
            check("t2_hold_word1", m_data[63:32], 32'hA000_0001);
            check("t2_hold_word31", m_data[1023:992], 32'hA000_001F);
            check("t2_hold_s_ready", s_ready, 1'b0);
            check("t2_hold_count", frame_count, 8'd1);
            tick();
        end
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        check("t2_release_valid", m_valid, 1'b0);
        check("t2_count", frame_count, 8'd2);
        tick();
        check("t2_single_handshake", frame_count, 8'd2);

        // Short frame of five all-ones beats.
        for (int i = 0; i < 5; i++) send_beat(32'hFFFF_FFFF, i == 4);
        check("t3_m_valid", m_valid, 1'b1);
        check("t3_low_bits", m_data[159:0], {160{1'b1}});
        check("t3_high_bits", m_data[1023:160], '0);
        check("t3_frame_err", frame_err, 1'b1);
        check("t3_beat_idx", beat_idx, 5'd0);
        tick();
        check("t3_err_pulse_end", frame_err, 1'b0);
        check("t3_still_valid", m_valid, 1'b1);
        m_ready = 1'b1;
        tick();
        check("t3_count", frame_count, 8'd3);

        // Reset in the middle of a frame.
        for (int i = 0; i < 17; i++) send_beat(32'(i), 1'b0);
        check("t4_idx17", beat_idx, 5'd17);
        reset_n = 1'b0;
        #1;
        check("t4_rst_idx", beat_idx, 5'd0);
        check("t4_rst_count", frame_count, 8'd0);
        check("t4_rst_valid", m_valid, 1'b0);
        check("t4_rst_data", m_data, '0);
        @(negedge main_clk_100mhz);
        reset_n = 1'b1;
        tick();
        for (int i = 0; i < 32; i++) send_beat(32'(i * 3 + 1), 1'b0);
        check("t4_m_valid", m_valid, 1'b1);
        check("t4_word0", m_data[31:0], 32'd1);
        check("t4_word16", m_data[543:512], 32'd49);
        check("t4_word31", m_data[1023:992], 32'd94);
        tick();
        check("t4_count", frame_count, 8'd1);

        // Single-beat short frames until the counter wraps.
        send_beat(32'h1234_5678, 1'b1);
        check("t5_err", frame_err, 1'b1);
        check("t5_data", m_data[63:0], 64'h0000_0000_1234_5678);
        check("t5_idx", beat_idx, 5'd0);
        for (int i = 0; i < 253; i++) send_beat(32'(i), 1'b1);
        tick();
        check("t5_count_max", frame_count, 8'd255);
        send_beat(32'h0BAD_F00D, 1'b1);
        tick();
        check("t5_count_wrap", frame_count, 8'd0);
        check("t5_idle_valid", m_valid, 1'b0);

`ifdef WIDE_ASM_OVERLAP_EN
        // Continuous stream: two frames, no idle cycle on s_ready.
        m_ready = 1'b1;
        s_valid = 1'b1;
        for (int i = 0; i < 64; i++) begin
            s_data = 32'(i);
            check("ov_s_ready", s_ready, 1'b1);
            tick();
            if (i == 31 || i == 63) begin
                check("ov_m_valid", m_valid, 1'b1);
                check("ov_low_word", m_data[31:0], 32'(i - 31));
                check("ov_high_word", m_data[1023:992], 32'(i));
            end
        end
        s_valid = 1'b0;
        tick();
        check("ov_count", frame_count, 8'd2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wide_bus_assembler.md
Name: wide_bus_assembler

Overview:
Upstream feeder for the IP top's 1024-bit ext_ultra_wide_bus input. Collects narrow valid/ready beats into a full-width word and presents it on a held valid/ready output port. Sits between the narrow external ingress path and the IP's ultra-wide bus input. Runs entirely in the main_clk_100mhz domain.

Parameters:
IN_W, 32, input beat width in bits; must divide OUT_W.
OUT_W, 1024, assembled output width in bits.
BEATS, OUT_W/IN_W (localparam, derived), beats per frame (32 by default).
CNT_W, 16, width of frame_count.

Ports:
main_clk_100mhz  input  1  system clock, rising edge.
reset_n  input  1  reset.
s_data  input  IN_W  input beat.
s_valid  input  1  input beat valid.
s_last  input  1  marks the final beat of a short frame; optional on a full frame.
s_ready  output  1  block accepts a beat.
m_data  output  OUT_W  assembled frame.
m_valid  output  1  m_data valid.
m_ready  input  1  consumer accepts the frame.
beat_idx  output  clog2(BEATS)  next slot to fill.
frame_err  output  1  one-cycle pulse: short frame delivered.
frame_count  output  CNT_W  delivered frames, wraps modulo 2^CNT_W.

Behaviour:
- Reset: asynchronous, active-low, on reset_n; clock is main_clk_100mhz.
  - Reset values: m_valid=0, m_data=0, beat_idx=0, frame_err=0, frame_count=0, internal accumulator=0.
  - Mid-operation reset discards a partial frame and any held output frame.
- Storage: separate accumulator (acc, OUT_W) and output register (m_data).
- Beat accept: s_valid && s_ready. Beat k is written to acc[k*IN_W +: IN_W], LSB-first (beat 0 goes to bits [IN_W-1:0]).
- Frame completion: an accepted beat with beat_idx==BEATS-1, or an accepted beat with s_last=1.
  - Same edge: m_data <= completed word and m_valid <= 1 on the next cycle (latency 1 cycle from the final beat's acceptance).
  - Same edge: beat_idx <= 0 and acc is cleared.
- Short frame: s_last=1 with beat_idx<BEATS-1.
  - Unfilled upper slots read 0 in m_data.
  - frame_err pulses high for exactly 1 cycle, coincident with the first m_valid cycle.
- s_last=1 on beat BEATS-1: normal completion, frame_err=0.
- Output handshake:
  - m_data stays stable while m_valid=1 && m_ready=0.
  - On m_valid && m_ready: m_valid <= 0 unless a new frame completes the same cycle (then m_valid stays 1 with new data), and frame_count increments.
  - m_ready while m_valid=0 is ignored.
- s_ready (feature off): s_ready = !m_valid. This gives one bubble cycle between frames, because s_ready is low during the handshake cycle.
- Wrap: frame_count rolls from 2^CNT_W-1 to 0 with no flag.
- FSM states:
  - FILL: m_valid=0.
  - HOLD: m_valid=1.
  - Transitions: FILL->HOLD on completion; HOLD->FILL on handshake without a concurrent completion; HOLD->HOLD on handshake with a concurrent completion.

Optional Feature:
WIDE_ASM_OVERLAP_EN
- Defined: acc filling continues while in HOLD. s_ready = !(m_valid && !m_ready && completing_beat), where completing_beat means beat_idx==BEATS-1 or s_last.
  - Zero-bubble: back-to-back frames at one beat per cycle sustain full throughput.
  - A completing beat offered while the output is held stalls until m_ready.
- Undefined: s_ready = !m_valid, as above.

Test Plan:
- Reset, then 32 beats with s_data=beat index (0..31), m_ready=1 -> m_valid rises 1 cycle after beat 31; m_data[31:0]=0, m_data[1023:992]=31; frame_count=1; frame_err=0.
- Hold m_ready=0 for 10 cycles after completion -> m_data stable and m_valid=1 throughout; s_ready=0 (feature off); on m_ready=1, one handshake, then frame_count+1.
- 5 beats of 0xFFFFFFFF with s_last on beat 4 -> m_data[159:0] all ones, m_data[1023:160]=0; frame_err high for 1 cycle; beat_idx=0.
- Assert reset_n=0 after beat 17 -> all outputs reach reset values immediately; the next 32-beat frame assembles correctly from slot 0.
- Drive 65536 single-beat s_last frames -> frame_count wraps to 0.
- With WIDE_ASM_OVERLAP_EN and continuous s_valid and m_ready -> two frames complete 32 cycles apart with no idle cycle on s_ready.
